// File: rtl/des_key_shift_sched.sv
// DES key-schedule C/D rotator: loads a PC1-permuted key and emits one rotated CD word per round.
// Optional end-of-schedule self-check enabled by defining DES_KEY_SCHED_CHECK_EN.
module des_key_shift_sched #(
  parameter int unsigned P_KEY_W   = 56,
  parameter bit          P_RESTART = 1'b0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [P_KEY_W-1:0] i_Key,
  input  logic               i_Decrypt,
  input  logic               i_Ready,
  output logic [P_KEY_W-1:0] o_Data,
  output logic               o_Valid,
  output logic [3:0]         o_Round,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Err
);

  localparam int unsigned H = P_KEY_W / 2;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [P_KEY_W-1:0] cd_q, cd_d;
  logic [3:0]         round_q, round_d;
  logic               done_q, done_d;
  logic               dec_q, dec_d;
  logic               load, accept, final_accept;

  function automatic logic [H-1:0] rot_half(input logic [H-1:0] x, input logic [1:0] amt,
                                            input logic right);
    case (amt)
      2'd0:    rot_half = x;
      2'd1:    rot_half = right ? {x[0], x[H-1:1]} : {x[H-2:0], x[H-1]};
      default: rot_half = right ? {x[1:0], x[H-1:2]} : {x[H-3:0], x[H-1:H-2]};
    endcase
  endfunction

  // Decrypt round 1 uses no shift so its CD equals the loaded key.
  function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic dec);
    if (r == 4'd0)                                   shift_amt = dec ? 2'd0 : 2'd1;
    else if (r == 4'd1 || r == 4'd8 || r == 4'd15)   shift_amt = 2'd1;
    else                                             shift_amt = 2'd2;
  endfunction

  function automatic logic [P_KEY_W-1:0] shift_cd(input logic [P_KEY_W-1:0] cd, input logic dec,
                                                  input logic [3:0] r);
    logic [1:0] amt;
    amt      = shift_amt(r, dec);
    shift_cd = {rot_half(cd[P_KEY_W-1:H], amt, dec), rot_half(cd[H-1:0], amt, dec)};
  endfunction

  assign load         = i_Start && (state_q == StIdle || P_RESTART);
  assign accept       = (state_q == StRun) && i_Ready;
  assign final_accept = accept && (round_q == 4'd15);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = StRun;
      cd_d    = shift_cd(i_Key, i_Decrypt, 4'd0);
      round_d = 4'd0;
      dec_d   = i_Decrypt;
    end else if (accept) begin
      if (round_q == 4'd15) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        cd_d    = shift_cd(cd_q, dec_q, round_q + 4'd1);
        round_d = round_q + 4'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
    end
  end

  assign o_Data  = cd_q;
  assign o_Valid = (state_q == StRun);
  assign o_Busy  = (state_q == StRun);
  assign o_Round = round_q;
  assign o_Done  = done_q;

`ifdef DES_KEY_SCHED_CHECK_EN
  logic [P_KEY_W-1:0] shadow_q;
  logic [P_KEY_W-1:0] cd_total;
  logic               err_q;

  // Decrypt totals 27 right shifts, so one more right step realigns with the key.
  assign cd_total = dec_q ? {rot_half(cd_q[P_KEY_W-1:H], 2'd1, 1'b1),
                             rot_half(cd_q[H-1:0], 2'd1, 1'b1)} : cd_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (final_accept && cd_total != shadow_q) err_q <= 1'b1;
      if (load) shadow_q <= i_Key;
    end
  end

  assign o_Err = err_q;
`else
  assign o_Err = 1'b0;
`endif

endmodule
